// File: rtl/jump_event_generator.sv
// Debounces a jump push-button and turns accepted presses into frame-aligned, acknowledged jump requests.
// Optional feature macro: JUMP_AUTO_REPEAT_EN adds frame-counted auto-repeat while the key stays held.
`timescale 1ns/1ps

module jump_event_generator #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_FRAMES   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_key,
    input  logic        frame_rt_clk,
    input  logic        jump_ack,
    output logic        jump_req,
    output logic        key_state,
    output logic [15:0] press_count,
    output logic [7:0]  dropped_count
);

    localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [DEB_W-1:0] debCnt_q, debCnt_d;

    logic keySync1_q, keySync2_q;
    logic frameSync1_q, frameSync2_q, framePrev_q;
    logic keyLevel;
    logic frameTick;

    logic        pending_q, pending_d;
    logic        jumpReq_q, jumpReq_d;
    logic [15:0] pressCount_q, pressCount_d;
    logic [7:0]  droppedCount_q, droppedCount_d;

    logic debouncedPress;
    logic repeatPress;
    logic pressEvent;
    logic launch;

    // Both asynchronous inputs pass two flops; a third flop on the frame path gives the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            keySync1_q   <= 1'b0;
            keySync2_q   <= 1'b0;
            frameSync1_q <= 1'b0;
            frameSync2_q <= 1'b0;
            framePrev_q  <= 1'b0;
        end else begin
            keySync1_q   <= jump_key;
            keySync2_q   <= keySync1_q;
            frameSync1_q <= frame_rt_clk;
            frameSync2_q <= frameSync1_q;
            framePrev_q  <= frameSync2_q;
        end
    end

    assign keyLevel  = keySync2_q;
    assign frameTick = frameSync2_q & ~framePrev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            debCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            debCnt_q <= debCnt_d;
        end
    end

    // The counter only advances while a wait state sees a stable level; any transition zeroes it.
    always_comb begin
        state_d        = state_q;
        debCnt_d       = '0;
        debouncedPress = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (keyLevel) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!keyLevel) begin
                    state_d = IDLE;
                end else if (debCnt_q == DEB_LAST) begin
                    state_d        = HELD;
                    debouncedPress = 1'b1;
                end else begin
                    debCnt_d = debCnt_q + DEB_W'(1);
                end
            end
            HELD: begin
                if (!keyLevel) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (keyLevel) begin
                    state_d = HELD;
                end else if (debCnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    debCnt_d = debCnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef JUMP_AUTO_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] frameCnt_q, frameCnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            frameCnt_q <= '0;
        end else begin
            frameCnt_q <= frameCnt_d;
        end
    end

    // Held outside HELD at zero, so every entry into HELD starts a fresh repeat interval.
    always_comb begin
        frameCnt_d  = frameCnt_q;
        repeatPress = 1'b0;
        if (state_q != HELD) begin
            frameCnt_d = '0;
        end else if (frameTick) begin
            if (frameCnt_q == REP_LAST) begin
                frameCnt_d  = '0;
                repeatPress = 1'b1;
            end else begin
                frameCnt_d = frameCnt_q + REP_W'(1);
            end
        end
    end
`else
    assign repeatPress = 1'b0;

    // REPEAT_FRAMES has no effect when auto-repeat is compiled out.
    if (REPEAT_FRAMES < 1) begin : gRepeatFramesUnused
    end
`endif

    assign pressEvent = debouncedPress | repeatPress;

    // A press landing on the tick itself launches immediately; an outstanding request blocks launch.
    assign launch = frameTick & (pending_q | pressEvent) & ~jumpReq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= 1'b0;
            jumpReq_q      <= 1'b0;
            pressCount_q   <= '0;
            droppedCount_q <= '0;
        end else begin
            pending_q      <= pending_d;
            jumpReq_q      <= jumpReq_d;
            pressCount_q   <= pressCount_d;
            droppedCount_q <= droppedCount_d;
        end
    end

    always_comb begin
        pending_d      = pending_q;
        jumpReq_d      = jumpReq_q;
        pressCount_d   = pressCount_q;
        droppedCount_d = droppedCount_q;
        if (pressEvent) begin
            pressCount_d = pressCount_q + 16'd1;
            pending_d    = 1'b1;
            if ((pending_q || jumpReq_q) && (droppedCount_q != 8'hFF)) begin
                droppedCount_d = droppedCount_q + 8'd1;
            end
        end
        if (launch) begin
            jumpReq_d = 1'b1;
            pending_d = 1'b0;
        end else if (jumpReq_q && jump_ack) begin
            jumpReq_d = 1'b0;
        end
    end

    assign jump_req      = jumpReq_q;
    assign key_state     = (state_q == HELD) || (state_q == RELEASE_WAIT);
    assign press_count   = pressCount_q;
    assign dropped_count = droppedCount_q;

endmodule

// File: tb/tb_jump_event_generator.sv
// Directed bench for jump_event_generator with DEBOUNCE_CYCLES=4, REPEAT_FRAMES=3 and a 40-cycle frame clock.
// Expected values are worked out by hand from the synchroniser, debounce and frame-tick latencies.
`timescale 1ns/1ps

module tb_jump_event_generator;

    localparam int DEBOUNCE = 4;
    localparam int REPEATS  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump_key;
    logic        frame_rt_clk;
    logic        jump_ack;
    logic        jump_req;
    logic        key_state;
    logic [15:0] press_count;
    logic [7:0]  dropped_count;

    int assertCount = 0;
    int failCount   = 0;
    int reqCycles   = 0;
    int reqBase;

    jump_event_generator #(
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .REPEAT_FRAMES  (REPEATS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .jump_key     (jump_key),
        .frame_rt_clk (frame_rt_clk),
        .jump_ack     (jump_ack),
        .jump_req     (jump_req),
        .key_state    (key_state),
        .press_count  (press_count),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    // Frame clock rises at 203 + 400*k, i.e. 2 ns before a clock rising edge.
    initial begin
        frame_rt_clk = 1'b0;
        #3;
        forever #200 frame_rt_clk = ~frame_rt_clk;
    end

    always @(negedge clk) begin
        if (jump_req === 1'b1) reqCycles <= reqCycles + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic key, input logic ack, input int cycles);
        jump_key = key;
        jump_ack = ack;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressKey();
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 3);
        reset = 1'b0;
    endtask

    // Leaves the bench on the first falling clock edge after a frame clock rise.
    task automatic alignToFrame();
        @(posedge frame_rt_clk);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        jump_key = 1'b0;
        jump_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_jump_req", jump_req, 0);
        checkOutput("reset_key_state", key_state, 0);
        checkOutput("reset_press_count", press_count, 0);
        checkOutput("reset_dropped_count", dropped_count, 0);
        reset = 1'b0;

        // Bounce never holds the key long enough to pass debounce.
        reqBase = reqCycles;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("bounce_press_count", press_count, 0);
        checkOutput("bounce_key_state", key_state, 0);
        checkOutput("bounce_req_cycles", reqCycles - reqBase, 0);

        // Clean press: 2 sync edges, 1 IDLE edge, 4 debounce edges.
        alignToFrame();
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("press_key_state_early", key_state, 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("press_key_state", key_state, 1);
        checkOutput("press_count_one", press_count, 1);
        checkOutput("press_req_before_tick", jump_req, 0);
        applyStimulus(1'b1, 1'b0, 13);
        applyStimulus(1'b0, 1'b0, 1);
        @(posedge frame_rt_clk);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("req_not_before_tick", jump_req, 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("req_after_tick", jump_req, 1);
        checkOutput("release_key_state", key_state, 0);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("req_held", jump_req, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("req_acked", jump_req, 0);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("req_stays_low", jump_req, 0);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("idle_ack_req", jump_req, 0);
        checkOutput("idle_ack_press_count", press_count, 1);
        alignToFrame();
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("no_spurious_req", jump_req, 0);

        // Unacknowledged presses pile up as drops and saturate.
        resetDut();
        repeat (3) pressKey();
        @(posedge frame_rt_clk);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("three_press_count", press_count, 3);
        checkOutput("three_dropped_count", dropped_count, 2);
        checkOutput("three_req", jump_req, 1);
        for (int i = 0; i < 297; i++) pressKey();
        checkOutput("sat_dropped_count", dropped_count, 255);
        checkOutput("sat_press_count", press_count, 300);

        // Reset with a live request throws everything away.
        resetDut();
        repeat (5) pressKey();
        @(posedge frame_rt_clk);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("pre_reset_req", jump_req, 1);
        checkOutput("pre_reset_press_count", press_count, 5);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("mid_reset_req", jump_req, 0);
        checkOutput("mid_reset_key_state", key_state, 0);
        checkOutput("mid_reset_press_count", press_count, 0);
        checkOutput("mid_reset_dropped_count", dropped_count, 0);
        applyStimulus(1'b0, 1'b0, 1);
        reset = 1'b0;
        reqBase = reqCycles;
        applyStimulus(1'b0, 1'b0, 100);
        checkOutput("post_reset_req_cycles", reqCycles - reqBase, 0);
        checkOutput("post_reset_press_count", press_count, 0);

        // A key held through reset is debounced again as a new press.
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("held_pre_reset_count", press_count, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("held_in_reset_key_state", key_state, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("held_redebounce_early", key_state, 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("held_redebounce_key_state", key_state, 1);
        checkOutput("held_redebounce_count", press_count, 1);
        applyStimulus(1'b0, 1'b0, 10);

        // Ack on the same cycle as a tick with a press pending: one frame of low request.
        resetDut();
        alignToFrame();
        pressKey();
        @(posedge frame_rt_clk);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("coinc_first_req", jump_req, 1);
        pressKey();
        checkOutput("coinc_dropped_count", dropped_count, 1);
        alignToFrame();
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("coinc_req_dropped", jump_req, 0);
        reqBase = reqCycles;
        applyStimulus(1'b0, 1'b0, 39);
        checkOutput("coinc_req_still_low", jump_req, 0);
        checkOutput("coinc_req_cycles", reqCycles - reqBase, 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("coinc_req_rises", jump_req, 1);

        // Ten frames held with prompt acks.
        resetDut();
        alignToFrame();
        for (int i = 0; i < 430; i++) applyStimulus(i < 400, jump_req, 1);
        applyStimulus(1'b0, 1'b0, 2);
`ifdef JUMP_AUTO_REPEAT_EN
        checkOutput("hold_press_count", press_count, 4);
`else
        checkOutput("hold_press_count", press_count, 1);
`endif
        checkOutput("hold_dropped_count", dropped_count, 0);
        checkOutput("hold_req_final", jump_req, 0);
        checkOutput("hold_key_state_final", key_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/jump_event_generator.md
JUMP_EVENT_GENERATOR -- requirements
Module: jump_event_generator

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles needed to accept a key change (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_FRAMES, default 12, frames between auto-repeat requests while the key is held.
REQ-003 SHALL have port clk, input, 1, system clock (100 MHz); the block uses one clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port jump_key, input, 1, raw asynchronous push-button level (1 = pressed).
REQ-006 SHALL have port frame_rt_clk, input, 1, 60 Hz frame-rate clock, sampled as data and never used as a clock.
REQ-007 SHALL have port jump_ack, input, 1, single-cycle pulse from the downstream input controller consuming the request.
REQ-008 SHALL have port jump_req, output, 1, frame-aligned jump request held until acknowledged.
REQ-009 SHALL have port key_state, output, 1, debounced key level.
REQ-010 SHALL have port press_count, output, 16, accepted presses, wrapping.
REQ-011 SHALL have port dropped_count, output, 8, presses lost while a request was pending, saturating.

Function
REQ-012 SHALL synchronise jump_key and frame_rt_clk through two flops each before any use.
REQ-013 SHALL generate an internal frame_tick for one cycle on each synchronised rising edge of frame_rt_clk.
REQ-014 SHALL run a debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-015 IDLE->PRESS_WAIT on synchronised key=1; PRESS_WAIT->HELD after DEBOUNCE_CYCLES consecutive key=1 cycles; PRESS_WAIT->IDLE on any key=0.
REQ-016 HELD->RELEASE_WAIT on key=0; RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive key=0 cycles; RELEASE_WAIT->HELD on any key=1.
REQ-017 key_state SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-018 The PRESS_WAIT->HELD transition SHALL be a press event: it increments press_count modulo 2^16 and sets an internal pending flag.
REQ-019 A press event while pending=1 or jump_req=1 SHALL increment dropped_count, saturating at 255, and leave pending set.
REQ-020 On frame_tick with pending=1 and jump_req=0, jump_req SHALL rise the following cycle and pending SHALL clear.
REQ-021 jump_req SHALL stay high until a cycle with jump_ack=1 and SHALL be 0 the next cycle.
REQ-022 jump_ack while jump_req=0 SHALL be ignored.
REQ-023 jump_ack and frame_tick in the same cycle with pending=1: jump_req drops for one cycle, then rises at the next frame_tick and not earlier.
REQ-024 Press event and frame_tick in the same cycle with jump_req=0: the request rises at that frame_tick, with one cycle of latency.
REQ-025 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).
REQ-026 The debounce counter SHALL clear on every FSM transition.

Reset
REQ-027 On reset SHALL set: FSM=IDLE, jump_req=0, key_state=0, press_count=0, dropped_count=0, pending=0, all counters and synchroniser flops=0.
REQ-028 Reset during PRESS_WAIT or with jump_req high SHALL discard the press or request; no event appears after reset deasserts.
REQ-029 A key held through reset SHALL be re-debounced from IDLE and counted as a new press.

Configuration
REQ-030 Macro JUMP_AUTO_REPEAT_EN defined: in HELD, a frame counter SHALL count frame_ticks and set pending every REPEAT_FRAMES ticks, counting each as a press event; the counter clears on HELD entry.
REQ-031 Macro JUMP_AUTO_REPEAT_EN undefined: no repeat logic, and exactly one press event per debounced press.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_FRAMES=3, frame_rt_clk period 40 cycles)
REQ-032 Key bounce 1,0,1,0 at 2-cycle intervals, then steady low -> no press event; press_count=0 and jump_req never high.
REQ-033 Key high 20 cycles -> key_state=1 at sync+4 cycles, press_count=1, jump_req rises the cycle after the next frame_tick and stays high; ack pulse -> jump_req=0 the next cycle.
REQ-034 Three clean presses with no ack -> press_count=3, dropped_count=2, jump_req high; after 300 unacked presses dropped_count=255.
REQ-035 Reset asserted while jump_req=1 and press_count=5 -> next cycle all outputs 0; no jump_req after release with the key low.
REQ-036 With JUMP_AUTO_REPEAT_EN, key held 10 frames and each request acked within 2 cycles -> press_count=4 (initial press + 3 repeats), dropped_count=0.
REQ-037 Ack coincident with frame_tick while pending=1 -> jump_req low for exactly one frame period, then high again.
